tx_srrc_interp_filter: RTL and testbench
========================================

# tx_srrc_interp_filter

Transmit-side pulse-shaping interpolator for the 4-ASK link. It maps one 2-bit symbol per symbol-enable to a 1s17 level and upsamples by 4 with zero-stuffing. It filters the result with the 81-tap symmetric SRRC response, producing one 1s17 sample per sample-enable. It implements the filter as a 4-phase polyphase structure over a 21-symbol delay line, so there are no multiplies by stuffed zeros. Its output is the input of the channel model and the receive matched filter.

## Interface
- COEFF_LEN, 81, total taps (odd, symmetric; h[n] = b[min(n, COEFF_LEN-1-n)])
- UPSAMPLE, 4, samples per symbol
- SYM_TAPS, 21, symbol delay-line depth = ceil(COEFF_LEN/UPSAMPLE)
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- sam_clk_en  in  1  sample-rate enable, one clk wide
- sym_clk_en  in  1  symbol-rate enable; always coincident with a sam_clk_en cycle, nominally every 4th
- tx_en  in  1  1 = shift mapped symbol; 0 = shift zero level (idle/gap)
- sym_in  in  2  4-ASK symbol, sampled only when sym_clk_en=1
- y  out  18  signed 1s17 shaped sample
- phase  out  2  polyphase index of the next sample to be produced

## Operation
- Level map, with L used in arithmetic: 00→L=-3, 01→L=-1, 10→L=+1, 11→L=+3, tx_en=0→L=0. Level value = L/4 (1s17: ±98304, ±32768, 0).
- Delay line s[0..20] holds L values as 3-bit signed. On sym_clk_en: s[0]←new L, s[k]←s[k-1].
- Phase counter ph:
  - On sam_clk_en without sym_clk_en: ph←ph+1 mod 4.
  - On sym_clk_en: ph←0, regardless of current ph. This is the resync rule; a sym_clk_en arriving when ph≠3 realigns and is not an error.
- Output, on every sam_clk_en edge: acc = Σ_{k=0..20, 4k+ph≤80} s[k]·h[4k+ph], using the pre-edge s and ph. The k=20 term exists only for ph=0.
- Products are formed by shift-add (3·h = (h<<1)+h, sign by negation). No general multipliers.
- Widths:
  - Each product is 20-bit signed.
  - acc is 25-bit signed and cannot overflow.
- Output scaling: y←sat18(acc>>>2), using an arithmetic shift (floor, no rounding).
- Saturation clamps to [-131072, +131071]; wrap-around is forbidden.
- Coefficients b[0..40] are 18-bit 1s17 constants from the team's TX SRRC design table; b[40] is the centre tap. The bench uses the same table.
- Reset: y=0, phase=0, all s[k]=0. Reset is honoured mid-stream; the first post-reset output uses an all-zero line.

## Timing
- Every register holds its value when its enable is low.
- Latency: a symbol captured at edge E0 (sym_clk_en) first contributes at the next sam_clk_en edge E1, as y = L·h[0]/4.
  - It then contributes h[1], h[2], h[3] on the following sam_clk_en edges.
  - It appears through h[80] at 20 symbols plus 1 sample after E0.
- phase updates on the same edge as y. After any sym_clk_en, phase reads 0.
- Simultaneous events:
  - A sym_clk_en edge computes y with the old line and old ph, and shifts the line on the same edge.
  - A sym_clk_en without sam_clk_en is out of contract; the block takes no action (no shift, no output).
- Steady-state throughput is one output per sam_clk_en with no stalls. The block has no backpressure.

## Test plan
- Reset, then run with tx_en=0 → y=0 and phase cycles 0,1,2,3 on every sam_clk_en. Assert reset mid-stream → y=0 and phase=0 immediately, asynchronously.
- Impulse: one symbol 11 with tx_en=1, then tx_en=0 for 25 symbols → the 81 outputs after E1 equal floor(3·h[n]/4) for n=0..80 in order, symmetric about n=40, then 0.
- Impulse with symbol 00 → outputs equal floor(-3·h[n]/4). Check floor behaviour on odd negative products.
- Resync: issue sym_clk_en after only 2 sam_clk_en → phase jumps to 0 and the next output uses h[0] for the new symbol. No X and no glitch on y.
- Saturation: worst-case symbol pattern with the sign of each s[k] matching sign(h[4k]) → y clamps to +131071. The inverse pattern clamps to -131072, and the sign never flips.
- Random 4-ASK stream of 2000 symbols vs a bit-true reference model → exact match on every sam_clk_en.

Source files
------------

// File: rtl/tx_srrc_interp_filter_if.sv
// Sample/symbol enables, symbol input and shaped-sample output of the
// transmit SRRC interpolator.
interface tx_srrc_interp_filter_if;
    localparam int unsigned SYM_W = 2;
    localparam int unsigned Y_W   = 18;
    localparam int unsigned PH_W  = 2;

    logic                    sam_clk_en;
    logic                    sym_clk_en;
    logic                    tx_en;
    logic [SYM_W-1:0]        sym_in;
    logic signed [Y_W-1:0]   y;
    logic [PH_W-1:0]         phase;

    modport master (
        output sam_clk_en, sym_clk_en, tx_en, sym_in,
        input  y, phase
    );

    modport slave (
        input  sam_clk_en, sym_clk_en, tx_en, sym_in,
        output y, phase
    );
endinterface

// File: rtl/tx_srrc_interp_filter.sv
// 4-ASK transmit pulse shaper: x4 zero-stuffing interpolation through an 81-tap
// symmetric SRRC response, built as a 4-phase polyphase filter on a symbol line.
module tx_srrc_interp_filter (
    input  logic                   clk,
    input  logic                   reset,
    tx_srrc_interp_filter_if.slave bus
);
    localparam int unsigned COEFF_LEN  = 81;
    localparam int unsigned UPSAMPLE   = 4;
    localparam int unsigned SYM_TAPS   = 21;
    localparam int unsigned HALF_LEN   = (COEFF_LEN + 1) / 2;
    localparam int unsigned COEF_W     = 18;
    localparam int unsigned LVL_W      = 3;
    localparam int unsigned PROD_W     = 20;
    localparam int unsigned ACC_W      = 25;
    localparam int unsigned Y_W        = 18;
    localparam int unsigned PH_W       = 2;
    localparam int unsigned OUT_SHIFT  = 2;
    localparam int unsigned COEF_IDX_W = $clog2(HALF_LEN);
    localparam int unsigned SYM_IDX_W  = $clog2(SYM_TAPS);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (Y_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 << (Y_W - 1)));

    // Half of the symmetric SRRC response, 1s17; index 40 is the centre tap.
    localparam logic signed [COEF_W-1:0] B [HALF_LEN] = '{
        18'sd39,     -18'sd310,   -18'sd386,   -18'sd99,    18'sd307,
        18'sd449,    18'sd150,    -18'sd363,   -18'sd620,   -18'sd320,
        18'sd357,    18'sd845,    18'sd658,    -18'sd146,   -18'sd930,
        -18'sd990,   -18'sd186,   18'sd837,    18'sd1141,   18'sd341,
        -18'sd920,   -18'sd1402,  -18'sd359,   18'sd1570,   18'sd2601,
        18'sd1218,   -18'sd2245,  -18'sd5239,  -18'sd4601,  18'sd739,
        18'sd8012,   18'sd11545,  18'sd6515,   -18'sd6748,  -18'sd20894,
        -18'sd24379, -18'sd7877,  18'sd29188,  18'sd76289,  18'sd115722,
        18'sd131071
    };

    logic signed [LVL_W-1:0] s_q [SYM_TAPS];
    logic [PH_W-1:0]         ph_q;
    logic signed [Y_W-1:0]   y_q;
    logic signed [LVL_W-1:0] lvl_c;
    logic signed [ACC_W-1:0] acc_c;
    logic signed [ACC_W-1:0] scaled_c;
    logic signed [Y_W-1:0]   y_next_c;

    function automatic logic signed [COEF_W-1:0] coef_at(input int unsigned n);
        int unsigned m;
        m = (n < COEFF_LEN - 1 - n) ? n : COEFF_LEN - 1 - n;
        return B[COEF_IDX_W'(m)];
    endfunction

    // Level times coefficient without a multiplier: |L| is 0, 1 or 3.
    function automatic logic signed [PROD_W-1:0] shape_prod(
        input logic signed [LVL_W-1:0]  lvl,
        input logic signed [COEF_W-1:0] coef
    );
        logic signed [PROD_W-1:0] c_ext;
        logic signed [PROD_W-1:0] mag;
        c_ext = PROD_W'(coef);
        case (lvl)
            LVL_W'(3), LVL_W'(-3): mag = (c_ext <<< 1) + c_ext;
            LVL_W'(1), LVL_W'(-1): mag = c_ext;
            default:               mag = '0;
        endcase
        return lvl[LVL_W-1] ? -mag : mag;
    endfunction

    // Symbol to level; an idle slot shifts in a zero level.
    always_comb begin
        lvl_c = '0;
        if (bus.tx_en) begin
            case (bus.sym_in)
                2'b00:   lvl_c = LVL_W'(-3);
                2'b01:   lvl_c = LVL_W'(-1);
                2'b10:   lvl_c = LVL_W'(1);
                default: lvl_c = LVL_W'(3);
            endcase
        end
    end

    // Polyphase sum for the current phase; only ph=0 reaches the last line slot.
    always_comb begin : poly_sum
        int unsigned tap;
        tap   = 0;
        acc_c = '0;
        for (int unsigned k = 0; k < SYM_TAPS; k++) begin
            tap = UPSAMPLE * k + 32'(ph_q);
            if (tap < COEFF_LEN) begin
                acc_c += ACC_W'(shape_prod(s_q[SYM_IDX_W'(k)], coef_at(tap)));
            end
        end
    end

    always_comb begin
        scaled_c = acc_c >>> OUT_SHIFT;
        if (scaled_c > SAT_HI) begin
            y_next_c = Y_W'(SAT_HI);
        end else if (scaled_c < SAT_LO) begin
            y_next_c = Y_W'(SAT_LO);
        end else begin
            y_next_c = Y_W'(scaled_c);
        end
    end

    // Output uses the pre-edge line and phase; a symbol edge shifts and resyncs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q  <= '0;
            ph_q <= '0;
            for (int unsigned k = 0; k < SYM_TAPS; k++) begin
                s_q[SYM_IDX_W'(k)] <= '0;
            end
        end else if (bus.sam_clk_en) begin
            y_q <= y_next_c;
            if (bus.sym_clk_en) begin
                ph_q   <= '0;
                s_q[0] <= lvl_c;
                for (int unsigned k = 1; k < SYM_TAPS; k++) begin
                    s_q[SYM_IDX_W'(k)] <= s_q[SYM_IDX_W'(k - 1)];
                end
            end else begin
                ph_q <= ph_q + PH_W'(1);
            end
        end
    end

    assign bus.y     = y_q;
    assign bus.phase = ph_q;
endmodule

// File: tb/tb_tx_srrc_interp_filter.sv
// Bench for tx_srrc_interp_filter: vector table for impulses, hand sequences for
// reset/resync/saturation, and a random 4-ASK stream against a reference model.
module tb_tx_srrc_interp_filter;
    localparam int SYM_TAPS = 21;
    localparam int LAST_TAP = 80;
    localparam int HALF     = 41;
    localparam int Y_MAX    = 131071;
    localparam int Y_MIN    = -131072;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tx_srrc_interp_filter_if bus ();

    tx_srrc_interp_filter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int b [HALF] = '{
        39, -310, -386, -99, 307, 449, 150, -363, -620, -320,
        357, 845, 658, -146, -930, -990, -186, 837, 1141, 341,
        -920, -1402, -359, 1570, 2601, 1218, -2245, -5239, -4601, 739,
        8012, 11545, 6515, -6748, -20894, -24379, -7877, 29188, 76289, 115722,
        131071
    };
    int lvl_tab [4] = '{-3, -1, 1, 3};

    typedef struct {
        logic [1:0] sym;
        logic       tx;
        int         exp_first;
        int         exp_centre;
    } vec_t;
    vec_t vecs [5];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: symbol levels newest first, phase, last output.
    int m_lv [$];
    int m_ph;
    int m_y;

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int h(input int n);
        return b[(n < LAST_TAP - n) ? n : LAST_TAP - n];
    endfunction

    function automatic int floor_div4(input int a);
        return (a >= 0) ? a / 4 : -((-a + 3) / 4);
    endfunction

    function automatic void model_reset();
        m_lv.delete();
        for (int k = 0; k < SYM_TAPS; k++) m_lv.push_back(0);
        m_ph = 0;
        m_y  = 0;
    endfunction

    function automatic void model_edge(input bit sym, input bit tx, input logic [1:0] sv);
        int acc;
        acc = 0;
        for (int k = 0; k < SYM_TAPS; k++)
            if (4 * k + m_ph <= LAST_TAP) acc += m_lv[k] * h(4 * k + m_ph);
        m_y = floor_div4(acc);
        if (m_y > Y_MAX) m_y = Y_MAX;
        if (m_y < Y_MIN) m_y = Y_MIN;
        if (sym) begin
            m_lv.push_front(tx ? lvl_tab[sv] : 0);
            void'(m_lv.pop_back());
            m_ph = 0;
        end else begin
            m_ph = (m_ph + 1) % 4;
        end
    endfunction

    // One clock: drive, clock, then compare against the model 1 ns after the edge.
    task automatic step(input bit sam, input bit sym, input bit tx, input logic [1:0] sv);
        bus.sam_clk_en = sam;
        bus.sym_clk_en = sym;
        bus.tx_en      = tx;
        bus.sym_in     = sv;
        @(posedge clk);
        if (sam) model_edge(sym, tx, sv);
        #1;
        bus.sam_clk_en = 1'b0;
        bus.sym_clk_en = 1'b0;
        chk("model_y", 32'(bus.y), m_y);
        chk("model_phase", 32'(bus.phase), m_ph);
    endtask

    task automatic flush();
        for (int i = 0; i < 4 * (SYM_TAPS + 1); i++) step(1'b1, (i % 4) == 0, 1'b0, 2'b00);
    endtask

    task automatic impulse(input vec_t v);
        int exp;
        flush();
        step(1'b1, 1'b1, v.tx, v.sym);
        for (int i = 1; i <= 84; i++) begin
            step(1'b1, (i % 4) == 0, 1'b0, 2'b00);
            if (i <= LAST_TAP + 1) begin
                exp = v.tx ? floor_div4(lvl_tab[v.sym] * h(i - 1)) : 0;
                chk("impulse_tap", 32'(bus.y), exp);
            end else begin
                chk("impulse_tail", 32'(bus.y), 0);
            end
            if (i == 1)  chk("impulse_first", 32'(bus.y), v.exp_first);
            if (i == 41) chk("impulse_centre", 32'(bus.y), v.exp_centre);
        end
    endtask

    task automatic saturate(input bit positive);
        int lv;
        flush();
        for (int j = 0; j < SYM_TAPS; j++) begin
            lv = (h(4 * (SYM_TAPS - 1 - j)) > 0) ? 3 : -3;
            if (!positive) lv = -lv;
            step(1'b1, 1'b1, 1'b1, (lv > 0) ? 2'b11 : 2'b00);
        end
        step(1'b1, 1'b0, 1'b0, 2'b00);
        if (positive) chk("sat_hi", 32'(bus.y), Y_MAX);
        else          chk("sat_lo", 32'(bus.y), Y_MIN);
    endtask

    initial begin
        vecs[0] = '{sym: 2'b11, tx: 1'b1, exp_first: 29,  exp_centre: 98303};
        vecs[1] = '{sym: 2'b00, tx: 1'b1, exp_first: -30, exp_centre: -98304};
        vecs[2] = '{sym: 2'b01, tx: 1'b1, exp_first: -10, exp_centre: -32768};
        vecs[3] = '{sym: 2'b10, tx: 1'b1, exp_first: 9,   exp_centre: 32767};
        vecs[4] = '{sym: 2'b11, tx: 1'b0, exp_first: 0,   exp_centre: 0};

        bus.sam_clk_en = 1'b0;
        bus.sym_clk_en = 1'b0;
        bus.tx_en      = 1'b0;
        bus.sym_in     = 2'b00;
        reset          = 1'b0;
        model_reset();
        #3;
        chk("reset_y", 32'(bus.y), 0);
        chk("reset_phase", 32'(bus.phase), 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Idle run: zero output, phase counting through 0..3.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 2'b00);
            chk("idle_y", 32'(bus.y), 0);
            chk("idle_phase", 32'(bus.phase), i % 4);
        end

        for (int v = 0; v < 5; v++) impulse(vecs[v]);

        // Resync after only two samples.
        flush();
        step(1'b1, 1'b1, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        chk("resync_pre_phase", 32'(bus.phase), 2);
        step(1'b1, 1'b1, 1'b1, 2'b11);
        chk("resync_phase", 32'(bus.phase), 0);
        step(1'b1, 1'b0, 1'b0, 2'b00);
        chk("resync_y", 32'(bus.y), 29);
        chk("resync_next_phase", 32'(bus.phase), 1);

        saturate(1'b1);
        saturate(1'b0);

        // Mid-stream asynchronous reset.
        step(1'b1, 1'b1, 1'b1, 2'b11);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 2'b00);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_y", 32'(bus.y), 0);
        chk("async_reset_phase", 32'(bus.phase), 0);
        model_reset();
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 2'b00);
        chk("post_reset_y", 32'(bus.y), 0);

        // Random 4-ASK stream with occasional resyncs and idle clocks.
        for (int s = 0; s < 2000; s++) begin
            bit          tx;
            logic [1:0]  sv;
            int          n_sam;
            tx    = ($urandom_range(0, 9) != 0);
            sv    = 2'($urandom_range(0, 3));
            n_sam = ($urandom_range(0, 99) < 85) ? 4 : int'($urandom_range(1, 6));
            for (int i = 0; i < n_sam; i++) begin
                if ($urandom_range(0, 3) == 0)
                    step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
                step(1'b1, i == 0, tx, sv);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
